codec_init_sequencer: RTL and testbench

CODEC_INIT_SEQUENCER -- requirements
Module: codec_init_sequencer

---
 rtl/codec_init_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_codec_init_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_init_sequencer.sv
// Codec init sequencer: walks a fixed 12-entry register table out to an I2C
// master, with NACK retries and a settle delay before the activate write,
// and accepts single software register writes while idle or done.
//
// Ports:
//   board_clk, reset      clock, synchronous active-high reset
//   start                 1-cycle pulse launching the init sequence
//   sw_req_valid/word     software write request {reg_addr[6:0], reg_data[8:0]}
//   sw_req_ready          request accepted this cycle (combinational handshake)
//   i2c_cmd_valid/ready   command handshake to the I2C master
//   i2c_cmd_dev_addr      codec slave address (DEV_ADDR)
//   i2c_cmd_word          word to write, stable while valid
//   i2c_cmd_done/nack     completion pulse and NACK flag from the I2C master
//   busy, init_done, init_error, sw_error   status
module codec_init_sequencer #(
    parameter logic [6:0]  DEV_ADDR     = 7'h1A,
    parameter int unsigned DELAY_CYCLES = 32'd1000,
    parameter int unsigned RETRY_MAX    = 2
) (
    input  logic        board_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sw_req_valid,
    input  logic [15:0] sw_req_word,
    output logic        sw_req_ready,
    output logic        i2c_cmd_valid,
    input  logic        i2c_cmd_ready,
    output logic [6:0]  i2c_cmd_dev_addr,
    output logic [15:0] i2c_cmd_word,
    input  logic        i2c_cmd_done,
    input  logic        i2c_cmd_nack,
    output logic        busy,
    output logic        init_done,
    output logic        init_error,
    output logic        sw_error
);

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned RETRY_W = $clog2(RETRY_MAX + 2);

    localparam logic [IDX_W-1:0] DELAY_IDX = 4'd9;
    localparam logic [IDX_W-1:0] ACTIVE_IDX = 4'd10;
    localparam logic [IDX_W-1:0] LAST_IDX  = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DELAY,
        S_DONE
    } state_t;

    // Fixed init table: R15 reset first, R9 (active) after the settle delay.
    function automatic logic [WORD_W-1:0] init_word(input logic [IDX_W-1:0] i);
        case (i)
            4'd0:    init_word = 16'h1E00;
            4'd1:    init_word = 16'h0C30;
            4'd2:    init_word = 16'h0017;
            4'd3:    init_word = 16'h0217;
            4'd4:    init_word = 16'h0479;
            4'd5:    init_word = 16'h0679;
            4'd6:    init_word = 16'h0810;
            4'd7:    init_word = 16'h0A00;
            4'd8:    init_word = 16'h0E0A;
            4'd9:    init_word = 16'h1000;
            4'd10:   init_word = 16'h1201;
            4'd11:   init_word = 16'h0C20;
            default: init_word = 16'h0000;
        endcase
    endfunction

    state_t               state_q, state_n;
    logic [IDX_W-1:0]     idx_q, idx_n;
    logic [RETRY_W-1:0]   retry_q, retry_n;
    logic [CNT_W-1:0]     delay_q, delay_n;
    logic                 src_sw_q, src_sw_n;
    logic                 cmd_valid_q, cmd_valid_n;
    logic [WORD_W-1:0]    cmd_word_q, cmd_word_n;
    logic                 busy_q, busy_n;
    logic                 init_done_q, init_done_n;
    logic                 init_error_q, init_error_n;
    logic                 sw_error_q, sw_error_n;
    logic                 accept_c;

    // State register and registered outputs.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            retry_q      <= '0;
            delay_q      <= '0;
            src_sw_q     <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_word_q   <= '0;
            busy_q       <= 1'b0;
            init_done_q  <= 1'b0;
            init_error_q <= 1'b0;
            sw_error_q   <= 1'b0;
        end else begin
            state_q      <= state_n;
            idx_q        <= idx_n;
            retry_q      <= retry_n;
            delay_q      <= delay_n;
            src_sw_q     <= src_sw_n;
            cmd_valid_q  <= cmd_valid_n;
            cmd_word_q   <= cmd_word_n;
            busy_q       <= busy_n;
            init_done_q  <= init_done_n;
            init_error_q <= init_error_n;
            sw_error_q   <= sw_error_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state_q;
        idx_n        = idx_q;
        retry_n      = retry_q;
        delay_n      = delay_q;
        src_sw_n     = src_sw_q;
        cmd_word_n   = cmd_word_q;
        init_done_n  = init_done_q;
        init_error_n = init_error_q;
        sw_error_n   = sw_error_q;
        accept_c     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                // start wins over a simultaneous software request
                if (start) begin
                    idx_n        = '0;
                    retry_n      = '0;
                    src_sw_n     = 1'b0;
                    init_done_n  = 1'b0;
                    init_error_n = 1'b0;
                    cmd_word_n   = init_word('0);
                    state_n      = S_ISSUE;
                end else if (sw_req_valid) begin
                    accept_c   = 1'b1;
                    retry_n    = '0;
                    src_sw_n   = 1'b1;
                    sw_error_n = 1'b0;
                    cmd_word_n = sw_req_word;
                    state_n    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_valid_q && i2c_cmd_ready) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i2c_cmd_done) begin
                    if (i2c_cmd_nack) begin
                        // cmd_word is held, so a retry simply re-enters ISSUE
                        if (retry_q < RETRY_W'(RETRY_MAX)) begin
                            retry_n = retry_q + RETRY_W'(1);
                            state_n = S_ISSUE;
                        end else begin
                            if (src_sw_q) begin
                                sw_error_n = 1'b1;
                            end else begin
                                init_error_n = 1'b1;
                            end
                            state_n = S_IDLE;
                        end
                    end else if (src_sw_q) begin
                        state_n = init_done_q ? S_DONE : S_IDLE;
                    end else if (idx_q == DELAY_IDX) begin
                        delay_n = '0;
                        state_n = S_DELAY;
                    end else if (idx_q == LAST_IDX) begin
                        init_done_n = 1'b1;
                        state_n     = S_DONE;
                    end else begin
                        idx_n      = idx_q + IDX_W'(1);
                        retry_n    = '0;
                        cmd_word_n = init_word(idx_q + IDX_W'(1));
                        state_n    = S_ISSUE;
                    end
                end
            end
            S_DELAY: begin
                if (delay_q == CNT_W'(DELAY_CYCLES - 1)) begin
                    idx_n      = ACTIVE_IDX;
                    retry_n    = '0;
                    cmd_word_n = init_word(ACTIVE_IDX);
                    state_n    = S_ISSUE;
                end else begin
                    delay_n = delay_q + CNT_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        cmd_valid_n = (state_n == S_ISSUE);
        busy_n      = (state_n == S_ISSUE) || (state_n == S_WAIT) || (state_n == S_DELAY);
    end

    // Ready is a same-cycle handshake; forced low while reset is asserted.
    assign sw_req_ready     = accept_c && !reset;
    assign i2c_cmd_valid    = cmd_valid_q;
    assign i2c_cmd_word     = cmd_word_q;
    assign i2c_cmd_dev_addr = DEV_ADDR;
    assign busy             = busy_q;
    assign init_done        = init_done_q;
    assign init_error       = init_error_q;
    assign sw_error         = sw_error_q;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Testbench for codec_init_sequencer: randomized I2C master model (ready
// stalls, ack latency, per-word NACK budgets) checked against a table-level
// reference of the expected command stream and status flags.
module tb_codec_init_sequencer;

    localparam int unsigned D_CYC = 16;
    localparam int unsigned R_MAX = 2;
    localparam logic [15:0] TABLE [12] = '{
        16'h1E00, 16'h0C30, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
        16'h0810, 16'h0A00, 16'h0E0A, 16'h1000, 16'h1201, 16'h0C20};

    logic        board_clk;
    logic        reset;
    logic        start;
    logic        sw_req_valid;
    logic [15:0] sw_req_word;
    logic        sw_req_ready;
    logic        i2c_cmd_valid;
    logic        i2c_cmd_ready;
    logic [6:0]  i2c_cmd_dev_addr;
    logic [15:0] i2c_cmd_word;
    logic        i2c_cmd_done;
    logic        i2c_cmd_nack;
    logic        busy;
    logic        init_done;
    logic        init_error;
    logic        sw_error;

    codec_init_sequencer #(
        .DEV_ADDR     (7'h1A),
        .DELAY_CYCLES (D_CYC),
        .RETRY_MAX    (R_MAX)
    ) dut (
        .board_clk        (board_clk),
        .reset            (reset),
        .start            (start),
        .sw_req_valid     (sw_req_valid),
        .sw_req_word      (sw_req_word),
        .sw_req_ready     (sw_req_ready),
        .i2c_cmd_valid    (i2c_cmd_valid),
        .i2c_cmd_ready    (i2c_cmd_ready),
        .i2c_cmd_dev_addr (i2c_cmd_dev_addr),
        .i2c_cmd_word     (i2c_cmd_word),
        .i2c_cmd_done     (i2c_cmd_done),
        .i2c_cmd_nack     (i2c_cmd_nack),
        .busy             (busy),
        .init_done        (init_done),
        .init_error       (init_error),
        .sw_error         (sw_error)
    );

    int          n_cmp;
    int          n_bad;
    int          cyc;
    int          lat_lo;
    int          lat_hi;
    int          stab_err;
    int          nk [12];
    int          nack_left [logic [15:0]];
    int          done_cyc_of [logic [15:0]];
    int          rise_cyc_of [logic [15:0]];
    logic [15:0] iss_q [$];
    logic [15:0] exp_q [$];
    bit          exp_err;

    initial begin
        board_clk = 1'b0;
        forever #5 board_clk = ~board_clk;
    end

    initial begin
        cyc = 0;
        forever @(posedge board_clk) cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected command stream: each entry is tried (nacks+1) times, capped at
    // RETRY_MAX+1, and the sequence stops at the first word that exhausts it.
    task automatic model_init();
        exp_q.delete();
        exp_err = 1'b0;
        for (int i = 0; i < 12; i++) begin
            int tries;
            tries = (nk[i] > int'(R_MAX)) ? int'(R_MAX) + 1 : nk[i] + 1;
            for (int t = 0; t < tries; t++) exp_q.push_back(TABLE[i]);
            if (nk[i] > int'(R_MAX)) begin
                exp_err = 1'b1;
                break;
            end
        end
        nack_left.delete();
        for (int i = 0; i < 12; i++) if (nk[i] > 0) nack_left[TABLE[i]] = nk[i];
    endtask

    task automatic cmp_list(input string tag);
        chk({tag, "_count"}, 32'(iss_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < iss_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_word%0d", tag, i), 32'(iss_q[i]), 32'(exp_q[i]));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"},      32'(i2c_cmd_valid), 32'h0);
        chk({tag, "_word"},       32'(i2c_cmd_word),  32'h0);
        chk({tag, "_ready"},      32'(sw_req_ready),  32'h0);
        chk({tag, "_busy"},       32'(busy),          32'h0);
        chk({tag, "_init_done"},  32'(init_done),     32'h0);
        chk({tag, "_init_error"}, 32'(init_error),    32'h0);
        chk({tag, "_sw_error"},   32'(sw_error),      32'h0);
        chk({tag, "_dev_addr"},   32'(i2c_cmd_dev_addr), 32'h1A);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && busy; i++) @(negedge board_clk);
        chk({tag, "_timeout"}, 32'(busy), 32'h0);
    endtask

    task automatic run_init(input string tag);
        iss_q.delete();
        @(negedge board_clk);
        start = 1'b1;
        @(negedge board_clk);
        start = 1'b0;
        chk({tag, "_init_done_cleared"}, 32'(init_done), 32'h0);
        wait_idle(tag);
    endtask

    // Init with a software request held pending; ready must only appear in DONE.
    task automatic init_with_sw(input string tag, input bit together, input logic [15:0] w);
        int bad_ready;
        bit got;
        bad_ready = 0;
        got = 1'b0;
        for (int i = 0; i < 12; i++) nk[i] = 0;
        model_init();
        exp_q.push_back(w);
        iss_q.delete();
        @(negedge board_clk);
        start = 1'b1;
        if (together) begin
            sw_req_valid = 1'b1;
            sw_req_word  = w;
            #1;
            chk({tag, "_ready_vs_start"}, 32'(sw_req_ready), 32'h0);
        end
        @(negedge board_clk);
        start = 1'b0;
        sw_req_valid = 1'b1;
        sw_req_word  = w;
        for (int i = 0; i < 3000 && !got; i++) begin
            #1;
            if (sw_req_ready) begin
                got = 1'b1;
                if (busy || !init_done) bad_ready++;
                chk({tag, "_init_before_sw"}, 32'(iss_q.size()), 32'd12);
            end else begin
                @(negedge board_clk);
            end
        end
        chk({tag, "_ready_seen"}, 32'(got), 32'h1);
        chk({tag, "_ready_early"}, 32'(bad_ready), 32'h0);
        @(negedge board_clk);
        sw_req_valid = 1'b0;
        wait_idle(tag);
        cmp_list(tag);
        chk({tag, "_done_state"}, 32'(init_done), 32'h1);
    endtask

    // I2C master model: random ready stalls, ack after a random latency.
    initial begin : i2c_master
        int          timer;
        logic [15:0] pend_word;
        logic        pend_nack;
        logic        prev_valid;
        logic [15:0] prev_word;
        timer = 0;
        pend_word = '0;
        pend_nack = 1'b0;
        prev_valid = 1'b0;
        prev_word = '0;
        i2c_cmd_ready = 1'b0;
        i2c_cmd_done  = 1'b0;
        i2c_cmd_nack  = 1'b0;
        forever begin
            @(negedge board_clk);
            i2c_cmd_done = 1'b0;
            i2c_cmd_nack = 1'b0;
            if (timer > 0) begin
                timer--;
                if (timer == 0) begin
                    i2c_cmd_done = 1'b1;
                    i2c_cmd_nack = pend_nack;
                    done_cyc_of[pend_word] = cyc;
                end
            end
            if (i2c_cmd_valid && !prev_valid) rise_cyc_of[i2c_cmd_word] = cyc;
            if (i2c_cmd_valid && prev_valid && i2c_cmd_word !== prev_word) stab_err++;
            prev_valid = i2c_cmd_valid;
            prev_word  = i2c_cmd_word;
            i2c_cmd_ready = ($urandom_range(3, 0) != 0);
            if (i2c_cmd_valid && i2c_cmd_ready) begin
                iss_q.push_back(i2c_cmd_word);
                pend_word = i2c_cmd_word;
                pend_nack = nack_left.exists(pend_word) && nack_left[pend_word] > 0;
                if (pend_nack) nack_left[pend_word] = nack_left[pend_word] - 1;
                timer = int'($urandom_range(lat_hi, lat_lo));
            end
        end
    end

    initial begin : main
        logic [15:0] w;
        int          n_before;
        n_cmp = 0;
        n_bad = 0;
        stab_err = 0;
        lat_lo = 3;
        lat_hi = 3;
        reset = 1'b1;
        start = 1'b0;
        sw_req_valid = 1'b0;
        sw_req_word = '0;
        repeat (3) @(negedge board_clk);
        check_reset_values("reset");
        reset = 1'b0;

        // Clean init, 3-cycle ack, settle gap before R9
        for (int i = 0; i < 12; i++) nk[i] = 0;
        model_init();
        run_init("clean");
        cmp_list("clean");
        chk("clean_init_done", 32'(init_done), 32'h1);
        chk("clean_init_error", 32'(init_error), 32'h0);
        chk("clean_gap_r9", 32'(rise_cyc_of[16'h1201] - done_cyc_of[16'h1000]), 32'(D_CYC + 1));
        chk("clean_gap_normal", 32'(rise_cyc_of[16'h0017] - done_cyc_of[16'h0C30]), 32'h1);

        // Single NACK on entry 2, rerun from DONE
        lat_lo = 1;
        lat_hi = 5;
        for (int i = 0; i < 12; i++) nk[i] = 0;
        nk[2] = 1;
        model_init();
        run_init("nack_once");
        cmp_list("nack_once");
        chk("nack_once_init_done", 32'(init_done), 32'h1);
        chk("nack_once_init_error", 32'(init_error), 32'h0);

        // Entry 4 exhausts its retries
        for (int i = 0; i < 12; i++) nk[i] = 0;
        nk[4] = 3;
        model_init();
        run_init("nack_fail");
        cmp_list("nack_fail");
        chk("nack_fail_init_error", 32'(init_error), 32'h1);
        chk("nack_fail_init_done", 32'(init_done), 32'h0);

        // start and sw request together in IDLE
        w = 16'($urandom);
        init_with_sw("start_prio", 1'b1, w);

        // Single sw write from DONE
        nack_left.delete();
        iss_q.delete();
        @(negedge board_clk);
        sw_req_valid = 1'b1;
        sw_req_word  = 16'h0A08;
        #1;
        chk("sw_ready_pulse", 32'(sw_req_ready), 32'h1);
        @(negedge board_clk);
        sw_req_valid = 1'b0;
        #1;
        chk("sw_ready_drop", 32'(sw_req_ready), 32'h0);
        chk("sw_busy", 32'(busy), 32'h1);
        wait_idle("sw");
        chk("sw_count", 32'(iss_q.size()), 32'h1);
        if (iss_q.size() > 0) chk("sw_word", 32'(iss_q[0]), 32'h0A08);
        chk("sw_back_done", 32'(init_done), 32'h1);
        chk("sw_error_clr", 32'(sw_error), 32'h0);

        // sw request held through a rerun (covers DELAY)
        init_with_sw("sw_in_delay", 1'b0, 16'h0A08);

        // Randomized NACK patterns
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 12; i++)
                nk[i] = ($urandom_range(5, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
            model_init();
            run_init($sformatf("rand%0d", r));
            cmp_list($sformatf("rand%0d", r));
            chk($sformatf("rand%0d_init_error", r), 32'(init_error), 32'(exp_err));
            chk($sformatf("rand%0d_init_done", r), 32'(init_done), 32'(!exp_err));
        end

        // sw write that exhausts its retries
        w = 16'($urandom);
        nack_left.delete();
        nack_left[w] = 3;
        iss_q.delete();
        @(negedge board_clk);
        sw_req_valid = 1'b1;
        sw_req_word  = w;
        #1;
        chk("swfail_ready", 32'(sw_req_ready), 32'h1);
        @(negedge board_clk);
        sw_req_valid = 1'b0;
        wait_idle("swfail");
        chk("swfail_count", 32'(iss_q.size()), 32'(R_MAX + 1));
        chk("swfail_sw_error", 32'(sw_error), 32'h1);

        // Reset while waiting on entry 5, late done must be ignored
        lat_lo = 5;
        lat_hi = 5;
        for (int i = 0; i < 12; i++) nk[i] = 0;
        model_init();
        iss_q.delete();
        @(negedge board_clk);
        start = 1'b1;
        @(negedge board_clk);
        start = 1'b0;
        for (int i = 0; i < 3000 && iss_q.size() < 6; i++) @(negedge board_clk);
        chk("rst_reached_entry5", 32'(iss_q.size()), 32'h6);
        reset = 1'b1;
        @(negedge board_clk);
        check_reset_values("rst_mid");
        reset = 1'b0;
        n_before = iss_q.size();
        repeat (30) @(negedge board_clk);
        check_reset_values("rst_after");
        chk("rst_no_cmds", 32'(iss_q.size()), 32'(n_before));

        chk("word_stable", 32'(stab_err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
